// File: rtl/rsa_job_ctrl.sv
// Key-setup sequencer and round-robin arbiter sharing one modexp engine between encrypt and
// decrypt requesters. Define RSA_JOB_CTRL_TIMEOUT_EN to add the sticky engine watchdog.
module rsa_job_ctrl #(
  parameter int unsigned W       = 8,
  parameter int unsigned P       = 3,
  parameter int unsigned Q       = 7,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         kg_start,
  input  logic         kg_done,
  input  logic [W-1:0] e_key,
  input  logic [W-1:0] d_key,
  output logic         key_ready,
  input  logic         enc_req,
  input  logic [W-1:0] enc_data,
  output logic         enc_ack,
  output logic         enc_valid,
  output logic [W-1:0] enc_result,
  input  logic         dec_req,
  input  logic [W-1:0] dec_data,
  output logic         dec_ack,
  output logic         dec_valid,
  output logic [W-1:0] dec_result,
  output logic         eng_start,
  output logic [W-1:0] eng_base,
  output logic [W-1:0] eng_exp,
  output logic [W-1:0] eng_mod,
  input  logic         eng_done,
  input  logic [W-1:0] eng_result,
  output logic         busy,
  output logic         err
);

  localparam logic [W-1:0] N = W'(P * Q);

  typedef enum logic [2:0] {StIdle, StKeygen, StReady, StIssue, StRun} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] e_q, d_q, base_q;
  logic         grant_dec_q;
  logic         last_dec_q;
  logic         win_enc, win_dec;
  logic         finish, timeout;
  logic [W-1:0] done_res;

  assign finish   = (state_q == StRun) && (eng_done || timeout);
  assign done_res = eng_done ? eng_result : '0;
  assign busy     = state_q inside {StKeygen, StIssue, StRun};

  always_comb begin
    state_d = state_q;
    win_enc = 1'b0;
    win_dec = 1'b0;
    case (state_q)
      StIdle:   if (start) state_d = StKeygen;
      StKeygen: if (kg_done) state_d = StReady;
      StReady: begin
        // On a tie the port that was not served last wins.
        win_enc = enc_req && (!dec_req || last_dec_q);
        win_dec = dec_req && !win_enc;
        if (enc_req || dec_req) state_d = StIssue;
      end
      StIssue:  state_d = StRun;
      StRun:    if (finish) state_d = StReady;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kg_start    <= 1'b0;
      key_ready   <= 1'b0;
      e_q         <= '0;
      d_q         <= '0;
      base_q      <= '0;
      grant_dec_q <= 1'b0;
      last_dec_q  <= 1'b1;
      enc_ack     <= 1'b0;
      dec_ack     <= 1'b0;
      enc_valid   <= 1'b0;
      dec_valid   <= 1'b0;
      enc_result  <= '0;
      dec_result  <= '0;
      eng_start   <= 1'b0;
      eng_base    <= '0;
      eng_exp     <= '0;
      eng_mod     <= '0;
    end else begin
      kg_start <= (state_q == StIdle) && start;
      if ((state_q == StKeygen) && kg_done) begin
        e_q       <= e_key;
        d_q       <= d_key;
        key_ready <= 1'b1;
      end
      enc_ack <= win_enc;
      dec_ack <= win_dec;
      if (win_enc) begin
        base_q      <= enc_data % N;
        grant_dec_q <= 1'b0;
      end else if (win_dec) begin
        base_q      <= dec_data % N;
        grant_dec_q <= 1'b1;
      end
      eng_start <= (state_q == StIssue);
      if (state_q == StIssue) begin
        eng_base   <= base_q;
        eng_exp    <= grant_dec_q ? d_q : e_q;
        eng_mod    <= N;
        last_dec_q <= grant_dec_q;
      end
      enc_valid <= finish && !grant_dec_q;
      dec_valid <= finish && grant_dec_q;
      if (finish) begin
        if (grant_dec_q) dec_result <= done_res;
        else             enc_result <= done_res;
      end
    end
  end

`ifdef RSA_JOB_CTRL_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q;

  // Fires on the TIMEOUT-th consecutive RUN cycle without eng_done.
  assign timeout = (state_q == StRun) && !eng_done && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      cnt_q <= (state_q == StRun) ? cnt_q + 1'b1 : '0;
      if (timeout) err <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_job_ctrl.sv
// Self-checking bench for rsa_job_ctrl: directed vector table, abort/drop sequences and a
// randomized phase scored against a transaction-level model with a behavioural modexp engine.
module tb_rsa_job_ctrl;
  localparam int unsigned W = 8;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, kg_done = 1'b0;
  logic [W-1:0] e_key = '0, d_key = '0;
  logic         enc_req = 1'b0, dec_req = 1'b0;
  logic [W-1:0] enc_data = '0, dec_data = '0;
  logic         eng_done = 1'b0;
  logic [W-1:0] eng_result = '0;
  logic         kg_start, key_ready, enc_ack, enc_valid, dec_ack, dec_valid;
  logic         eng_start, busy, err;
  logic [W-1:0] enc_result, dec_result, eng_base, eng_exp, eng_mod;

  int           n_cmp = 0, n_bad = 0;
  int           eng_lat = 0, eng_cnt = -1;
  bit           eng_en = 1'b1;
  logic [W-1:0] eng_pend = '0;
  logic [W-1:0] last_enc_res = '0, last_dec_res = '0;

  typedef struct {
    bit           er, dr;
    logic [W-1:0] ed, dd;
    bit           win_dec, keep;
    int           base, exp_e, res, lat;
  } vec_t;

  rsa_job_ctrl #(.W(W), .P(3), .Q(7), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .start(start), .kg_start(kg_start), .kg_done(kg_done),
    .e_key(e_key), .d_key(d_key), .key_ready(key_ready),
    .enc_req(enc_req), .enc_data(enc_data), .enc_ack(enc_ack), .enc_valid(enc_valid),
    .enc_result(enc_result),
    .dec_req(dec_req), .dec_data(dec_data), .dec_ack(dec_ack), .dec_valid(dec_valid),
    .dec_result(dec_result),
    .eng_start(eng_start), .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod),
    .eng_done(eng_done), .eng_result(eng_result), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int modexp(int b, int e, int m);
    int r;
    if (m == 0) return 0;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  // Engine model: computes base^exp mod m and raises eng_done eng_lat+1 cycles after eng_start.
  always @(posedge clk) begin
    #1;
    eng_done = 1'b0;
    if (eng_cnt == 0) begin
      eng_done   = 1'b1;
      eng_result = eng_pend;
    end
    if (eng_cnt >= 0) eng_cnt--;
    if (eng_start && eng_en) begin
      eng_pend = W'(modexp(int'(eng_base), int'(eng_exp), int'(eng_mod)));
      eng_cnt  = eng_lat;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic key_setup();
    start = 1'b1;
    tick();
    chk("kg_start_pulse", int'(kg_start), 1);
    chk("busy_keygen", int'(busy), 1);
    chk("key_ready_before", int'(key_ready), 0);
    tick();
    chk("kg_start_once", int'(kg_start), 0);
    start   = 1'b0;
    enc_req = 1'b1;
    tick();
    chk("keygen_no_ack", int'(enc_ack), 0);
    enc_req = 1'b0;
    e_key   = 8'd3;
    d_key   = 8'd7;
    kg_done = 1'b1;
    tick();
    kg_done = 1'b0;
    chk("key_ready", int'(key_ready), 1);
    chk("busy_after_keygen", int'(busy), 0);
    chk("err_clear", int'(err), 0);
  endtask

  // Called in a READY cycle (previous valid cycle); returns in this job's valid cycle.
  task automatic run_job(input bit er, input bit dr, input logic [W-1:0] ed,
                         input logic [W-1:0] dd, input bit win_dec, input bit keep,
                         input int base, input int exp_e, input int res, input int lat);
    int n;
    enc_req  = er;
    dec_req  = dr;
    enc_data = ed;
    dec_data = dd;
    eng_lat  = lat;
    tick();
    chk("valid_pulse", int'(enc_valid) + int'(dec_valid), 0);
    chk("ack", int'({enc_ack, dec_ack}), win_dec ? 1 : 2);
    if (!keep) begin
      if (win_dec) dec_req = 1'b0;
      else         enc_req = 1'b0;
    end
    tick();
    chk("ack_pulse", int'({enc_ack, dec_ack}), 0);
    chk("eng_start", int'(eng_start), 1);
    chk("eng_base", int'(eng_base), base);
    chk("eng_exp", int'(eng_exp), exp_e);
    chk("eng_mod", int'(eng_mod), 21);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(enc_valid || dec_valid) && n < 100);
    chk("valid_latency", n, lat + 2);
    chk("valid_port", int'({enc_valid, dec_valid}), win_dec ? 1 : 2);
    if (win_dec) last_dec_res = W'(res);
    else         last_enc_res = W'(res);
    chk("enc_result", int'(enc_result), int'(last_enc_res));
    chk("dec_result", int'(dec_result), int'(last_dec_res));
    chk("busy_ready", int'(busy), 0);
  endtask

  initial begin
    vec_t         tbl[10];
    bit           pend_enc, pend_dec, last_dec, wd, kp;
    logic [W-1:0] enc_d, dec_d;
    int           b, e, n, acc;

    // Rows follow one another; "last" starts as DEC after reset.
    tbl[0] = '{1'b1, 1'b1, 8'd5,   8'd20, 1'b0, 1'b0, 5,  3, 20, 3};
    tbl[1] = '{1'b0, 1'b1, 8'd5,   8'd20, 1'b1, 1'b1, 20, 7, 20, 0};
    tbl[2] = '{1'b1, 1'b1, 8'd5,   8'd20, 1'b0, 1'b1, 5,  3, 20, 5};
    tbl[3] = '{1'b1, 1'b1, 8'd5,   8'd20, 1'b1, 1'b1, 20, 7, 20, 1};
    tbl[4] = '{1'b1, 1'b1, 8'd5,   8'd20, 1'b0, 1'b0, 5,  3, 20, 2};
    tbl[5] = '{1'b1, 1'b0, 8'd4,   8'd20, 1'b0, 1'b0, 4,  3, 1,  10};
    tbl[6] = '{1'b0, 1'b1, 8'd4,   8'd25, 1'b1, 1'b0, 4,  7, 4,  4};
    tbl[7] = '{1'b1, 1'b1, 8'd255, 8'd21, 1'b0, 1'b0, 3,  3, 6,  0};
    tbl[8] = '{1'b0, 1'b1, 8'd255, 8'd21, 1'b1, 1'b0, 0,  7, 0,  6};
    tbl[9] = '{1'b1, 1'b1, 8'd20,  8'd1,  1'b0, 1'b0, 20, 3, 20, 2};

    tick();
    tick();
    chk("reset_ctrl", int'({kg_start, key_ready, enc_ack, enc_valid, dec_ack, dec_valid,
                            eng_start, busy, err}), 0);
    chk("reset_data", int'({eng_base, eng_exp, eng_mod, enc_result, dec_result}), 0);
    rst = 1'b0;
    kg_done = 1'b1;
    tick();
    kg_done = 1'b0;
    chk("idle_ignores_kg_done", int'({key_ready, busy}), 0);
    tick();
    key_setup();

    for (int i = 0; i < 10; i++)
      run_job(tbl[i].er, tbl[i].dr, tbl[i].ed, tbl[i].dd, tbl[i].win_dec, tbl[i].keep,
              tbl[i].base, tbl[i].exp_e, tbl[i].res, tbl[i].lat);

    // Randomized phase: decrypt from row 9 still pending, last served was ENC.
    pend_enc = 1'b0;
    pend_dec = 1'b1;
    enc_d    = 8'd20;
    dec_d    = 8'd1;
    last_dec = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!pend_enc && $urandom_range(0, 1) == 1) begin
        pend_enc = 1'b1;
        enc_d    = W'($urandom_range(0, 255));
      end
      if (!pend_dec && $urandom_range(0, 1) == 1) begin
        pend_dec = 1'b1;
        dec_d    = W'($urandom_range(0, 255));
      end
      if (!pend_enc && !pend_dec) begin
        if ($urandom_range(0, 1) == 1) pend_enc = 1'b1;
        else                           pend_dec = 1'b1;
      end
      wd = pend_dec && (!pend_enc || !last_dec);
      b  = int'(wd ? dec_d : enc_d) % 21;
      e  = wd ? 7 : 3;
      kp = ($urandom_range(0, 2) == 0);
      run_job(pend_enc, pend_dec, enc_d, dec_d, wd, kp, b, e, modexp(b, e, 21),
              int'($urandom_range(0, 6)));
      last_dec = wd;
      if (!kp) begin
        if (wd) pend_dec = 1'b0;
        else    pend_enc = 1'b0;
      end
    end

    // A decrypt request withdrawn before any ack is never served.
    enc_req  = 1'b1;
    dec_req  = 1'b0;
    enc_data = 8'd7;
    eng_lat  = 4;
    tick();
    chk("drop_enc_ack", int'(enc_ack), 1);
    enc_req  = 1'b0;
    dec_req  = 1'b1;
    dec_data = 8'd9;
    tick();
    dec_req = 1'b0;
    n   = 0;
    acc = 0;
    repeat (12) begin
      tick();
      n   += int'(enc_ack) + int'(dec_ack);
      acc += int'(enc_valid) + int'(dec_valid);
    end
    chk("drop_no_ack", n, 0);
    chk("drop_one_valid", acc, 1);
    chk("drop_enc_result", int'(enc_result), 7);

    // Asynchronous abort in RUN.
    enc_req  = 1'b1;
    enc_data = 8'd2;
    eng_lat  = 15;
    tick();
    chk("abort_ack", int'(enc_ack), 1);
    enc_req = 1'b0;
    tick();
    chk("abort_eng_start", int'(eng_start), 1);
    tick();
    tick();
    chk("abort_busy_run", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_ctrl", int'({kg_start, key_ready, enc_ack, enc_valid, dec_ack, dec_valid,
                            eng_start, busy, err}), 0);
    chk("abort_data", int'({eng_base, eng_exp, eng_mod, enc_result, dec_result}), 0);
    tick();
    rst          = 1'b0;
    last_enc_res = '0;
    last_dec_res = '0;
    enc_req      = 1'b1;
    dec_req      = 1'b1;
    n            = 0;
    repeat (30) begin
      tick();
      n += int'(enc_ack) + int'(dec_ack) + int'(enc_valid) + int'(dec_valid) +
           int'(kg_start) + int'(key_ready);
    end
    chk("abort_stays_idle", n, 0);
    enc_req = 1'b0;
    dec_req = 1'b0;
    key_setup();
    run_job(1'b1, 1'b1, 8'd10, 8'd11, 1'b0, 1'b0, 10, 3, 13, 1);

`ifdef RSA_JOB_CTRL_TIMEOUT_EN
    dec_req  = 1'b0;
    eng_en   = 1'b0;
    enc_req  = 1'b1;
    enc_data = 8'd4;
    tick();
    chk("to_ack", int'(enc_ack), 1);
    enc_req = 1'b0;
    tick();
    chk("to_eng_start", int'(eng_start), 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!enc_valid && n < 100);
    chk("to_latency", n, 20);
    chk("to_err", int'(err), 1);
    chk("to_result", int'(enc_result), 0);
    eng_en       = 1'b1;
    last_enc_res = '0;
    run_job(1'b0, 1'b1, 8'd0, 8'd5, 1'b1, 1'b0, 5, 7, 5, 2);
    chk("to_err_sticky", int'(err), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
